// File: rtl/deser_pkg.sv
// Shared encodings for the TBM frame sequencer: FSM states, output word kinds,
// status word layout and the small word-building helpers.
package deser_pkg;

  // FSM state encoding
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_HDR  = 3'd1;
  localparam logic [2:0] ST_ROC  = 3'd2;
  localparam logic [2:0] ST_TRL  = 3'd3;
  localparam logic [2:0] ST_STAT = 3'd4;

  // out_kind encoding
  localparam logic [1:0] KIND_HDR  = 2'd0;
  localparam logic [1:0] KIND_ROC  = 2'd1;
  localparam logic [1:0] KIND_TRL  = 2'd2;
  localparam logic [1:0] KIND_STAT = 2'd3;

  // Status word bit positions; roc_count occupies [4:0]
  localparam int STAT_OVF_BIT = 15;
  localparam int STAT_TMO_BIT = 14;
  localparam int STAT_HDR_BIT = 13;

  // Build the end-of-frame status word
  function automatic logic [15:0] status_word(input logic ovf, input logic tmo,
                                              input logic hdr, input logic [4:0] cnt);
    logic [15:0] w;
    w = 16'h0000;
    w[STAT_OVF_BIT] = ovf;
    w[STAT_TMO_BIT] = tmo;
    w[STAT_HDR_BIT] = hdr;
    w[4:0]          = cnt;
    return w;
  endfunction

  // Left-align 1..3 buffered nibbles (oldest in [11:8] when three are held), zero-pad the rest
  function automatic logic [15:0] pad_partial(input logic [11:0] w, input logic [1:0] cnt);
    logic [15:0] r;
    case (cnt)
      2'd1:    r = {w[3:0], 12'h000};
      2'd2:    r = {w[7:0], 8'h00};
      2'd3:    r = {w[11:0], 4'h0};
      default: r = 16'h0000;
    endcase
    return r;
  endfunction

  // Output kind of the segment the FSM is currently assembling
  function automatic logic [1:0] seg_kind(input logic [2:0] st);
    logic [1:0] k;
    case (st)
      ST_ROC:  k = KIND_ROC;
      ST_TRL:  k = KIND_TRL;
      default: k = KIND_HDR;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/word_fifo.sv
// First-word-fall-through word buffer; a push while full is taken only when a
// pop happens in the same cycle. almost_full means at most one free entry.
module word_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 18
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic             almost_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push_s, do_pop_s;

  assign empty       = (count_q == {CW{1'b0}});
  assign full        = (count_q == CW'(DEPTH));
  assign almost_full = (count_q >= CW'(DEPTH - 1));
  assign do_pop_s    = pop && !empty;
  assign do_push_s   = push && (!full || do_pop_s);
  assign rdata       = empty ? {WIDTH{1'b0}} : mem_q[rd_ptr_q];

  // Next pointers and occupancy
  always_comb begin
    wr_ptr_d = do_push_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop_s  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage and pointer registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push_s) begin
        mem_q[wr_ptr_q] <= wdata;
      end
    end
  end

endmodule

// File: rtl/tbm_frame_sequencer.sv
// TBM frame sequencer: packs header/ROC/trailer nibbles into 16-bit words,
// closes every frame with a status word, and buffers the words in word_fifo.
module tbm_frame_sequencer
  import deser_pkg::*;
#(
  parameter int TIMEOUT    = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        davail,
  input  logic [3:0]  din,
  input  logic        tbm_hdr,
  input  logic        tbm_trl,
  input  logic        roc_hdr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic [1:0]  out_kind,
  output logic [4:0]  roc_count,
  output logic        busy
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  logic [2:0]  state_q, state_d;
  logic [11:0] word_q, word_d;        // up to three pending nibbles, newest in [3:0]
  logic [1:0]  nib_cnt_q, nib_cnt_d;
  logic [4:0]  roc_count_q, roc_count_d;
  logic [7:0]  idle_cnt_q, idle_cnt_d;
  logic        err_ovf_q, err_ovf_d;
  logic        err_tmo_q, err_tmo_d;
  logic        err_hdr_q, err_hdr_d;
  logic [3:0]  stage_q, stage_d;      // first nibble of a frame that interrupted the previous one
  logic        restart_q, restart_d;

  logic        push_req_s, push_is_stat_s, fifo_push_s, fifo_pop_s;
  logic [15:0] push_word_s;
  logic [1:0]  push_kind_s;
  logic        fifo_full_s, fifo_empty_s, fifo_afull_s;
  logic        data_ok_s, stat_ok_s, in_trl_s;
  logic [17:0] fifo_rdata_s;

  assign out_valid  = !fifo_empty_s;
  assign fifo_pop_s = out_valid && out_ready;
  // Data may not consume the last free entry: it is kept for the status word
  assign data_ok_s  = !fifo_afull_s || fifo_pop_s;
  assign stat_ok_s  = !fifo_full_s || fifo_pop_s;
  assign in_trl_s   = (state_q == ST_TRL);
  assign out_data   = fifo_rdata_s[15:0];
  assign out_kind   = fifo_rdata_s[17:16];
  assign roc_count  = roc_count_q;
  assign busy       = (state_q != ST_IDLE);

  // Frame FSM, nibble packing and push arbitration
  always_comb begin
    state_d        = state_q;
    word_d         = word_q;
    nib_cnt_d      = nib_cnt_q;
    roc_count_d    = roc_count_q;
    idle_cnt_d     = idle_cnt_q;
    err_ovf_d      = err_ovf_q;
    err_tmo_d      = err_tmo_q;
    err_hdr_d      = err_hdr_q;
    stage_d        = stage_q;
    restart_d      = restart_q;
    push_req_s     = 1'b0;
    push_is_stat_s = 1'b0;
    push_word_s    = pad_partial(word_q, nib_cnt_q);
    push_kind_s    = seg_kind(state_q);
    fifo_push_s    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        idle_cnt_d = 8'd0;
        if (davail && tbm_hdr && enable) begin
          state_d     = ST_HDR;
          word_d      = {8'h00, din};
          nib_cnt_d   = 2'd1;
          roc_count_d = 5'd0;
          err_ovf_d   = 1'b0;
          err_tmo_d   = 1'b0;
          err_hdr_d   = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_HDR, ST_ROC, ST_TRL: begin
        if (davail) begin
          idle_cnt_d = 8'd0;
          if (tbm_hdr) begin
            // Flush the partial word now, emit status next cycle, then restart
            push_req_s = (nib_cnt_q != 2'd0);
            stage_d    = din;
            restart_d  = 1'b1;
            err_hdr_d  = 1'b1;
            nib_cnt_d  = 2'd0;
            state_d    = ST_STAT;
          end else if (tbm_trl && !in_trl_s) begin
            push_req_s = (nib_cnt_q != 2'd0);
            word_d     = {8'h00, din};
            nib_cnt_d  = 2'd1;
            state_d    = ST_TRL;
          end else if (roc_hdr && !in_trl_s) begin
            push_req_s  = (nib_cnt_q != 2'd0);
            word_d      = {8'h00, din};
            nib_cnt_d   = 2'd1;
            state_d     = ST_ROC;
            roc_count_d = (roc_count_q == 5'd31) ? 5'd31 : roc_count_q + 5'd1;
          end else begin
            word_d = {word_q[7:0], din};
            if (nib_cnt_q == 2'd3) begin
              push_req_s  = 1'b1;
              push_word_s = {word_q, din};
              nib_cnt_d   = 2'd0;
              state_d     = in_trl_s ? ST_STAT : state_q;
            end else begin
              nib_cnt_d = nib_cnt_q + 2'd1;
            end
          end
        end else if (idle_cnt_q == TMO_LAST) begin
          push_req_s = (nib_cnt_q != 2'd0);
          err_tmo_d  = 1'b1;
          nib_cnt_d  = 2'd0;
          state_d    = ST_STAT;
        end else begin
          idle_cnt_d = idle_cnt_q + 8'd1;
        end
      end

      ST_STAT: begin
        push_req_s     = 1'b1;
        push_is_stat_s = 1'b1;
        push_word_s    = status_word(err_ovf_q, err_tmo_q, err_hdr_q, roc_count_q);
        push_kind_s    = KIND_STAT;
        if (stat_ok_s && restart_q) begin
          state_d     = ST_HDR;
          word_d      = {8'h00, stage_q};
          nib_cnt_d   = 2'd1;
          roc_count_d = 5'd0;
          idle_cnt_d  = 8'd0;
          err_ovf_d   = 1'b0;
          err_tmo_d   = 1'b0;
          err_hdr_d   = 1'b0;
          restart_d   = 1'b0;
        end else if (stat_ok_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_STAT;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (push_req_s && push_is_stat_s) begin
      fifo_push_s = stat_ok_s;
    end else if (push_req_s && data_ok_s) begin
      fifo_push_s = 1'b1;
    end else if (push_req_s) begin
      err_ovf_d = 1'b1;
    end else begin
      fifo_push_s = 1'b0;
    end
  end

  // Sequencer state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      word_q      <= 12'h000;
      nib_cnt_q   <= 2'd0;
      roc_count_q <= 5'd0;
      idle_cnt_q  <= 8'd0;
      err_ovf_q   <= 1'b0;
      err_tmo_q   <= 1'b0;
      err_hdr_q   <= 1'b0;
      stage_q     <= 4'h0;
      restart_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      nib_cnt_q   <= nib_cnt_d;
      roc_count_q <= roc_count_d;
      idle_cnt_q  <= idle_cnt_d;
      err_ovf_q   <= err_ovf_d;
      err_tmo_q   <= err_tmo_d;
      err_hdr_q   <= err_hdr_d;
      stage_q     <= stage_d;
      restart_q   <= restart_d;
    end
  end

  word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (18)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (fifo_push_s),
    .wdata       ({push_kind_s, push_word_s}),
    .pop         (fifo_pop_s),
    .rdata       (fifo_rdata_s),
    .full        (fifo_full_s),
    .empty       (fifo_empty_s),
    .almost_full (fifo_afull_s)
  );

endmodule

// File: tb/tb_tbm_frame_sequencer.sv
// Directed bench for tbm_frame_sequencer: a cycle table for whole frames plus
// hand sequences for timeout, overflow/back-pressure and mid-frame reset.
module tb_tbm_frame_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic        davail = 1'b0;
  logic [3:0]  din = 4'h0;
  logic        tbm_hdr = 1'b0;
  logic        tbm_trl = 1'b0;
  logic        roc_hdr = 1'b0;
  logic        out_ready = 1'b1;
  logic        out_valid;
  logic [15:0] out_data;
  logic [1:0]  out_kind;
  logic [4:0]  roc_count;
  logic        busy;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic        dav;
    logic [3:0]  din;
    logic        th;
    logic        tt;
    logic        rh;
    logic        en;
    logic        ev;
    logic [15:0] ed;
    logic [1:0]  ek;
    logic        eb;
    logic [4:0]  er;
  } vec_t;

  vec_t vecs[$];

  tbm_frame_sequencer #(.TIMEOUT(8), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .davail    (davail),
    .din       (din),
    .tbm_hdr   (tbm_hdr),
    .tbm_trl   (tbm_trl),
    .roc_hdr   (roc_hdr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_kind  (out_kind),
    .roc_count (roc_count),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic dav, input logic [3:0] d, input logic th,
                              input logic tt, input logic rh, input logic en,
                              input logic ev, input logic [15:0] ed, input logic [1:0] ek,
                              input logic eb, input logic [4:0] er);
    vec_t v;
    v.dav = dav; v.din = d; v.th = th; v.tt = tt; v.rh = rh; v.en = en;
    v.ev = ev; v.ed = ed; v.ek = ek; v.eb = eb; v.er = er;
    return v;
  endfunction

  task automatic step(input logic dav, input logic [3:0] d, input logic th, input logic tt,
                      input logic rh, input logic en, input logic rdy);
    davail = dav; din = d; tbm_hdr = th; tbm_trl = tt; roc_hdr = rh;
    enable = en; out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic ev, input logic [15:0] ed,
                       input logic [1:0] ek, input logic eb, input logic [4:0] er);
    logic ok;
    n_vec++;
    ok = (out_valid === ev) && (busy === eb) && (roc_count === er);
    if (ev) ok = ok && (out_data === ed) && (out_kind === ek);
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got valid=%0b data=%h kind=%0d busy=%0b roc=%0d, want valid=%0b data=%h kind=%0d busy=%0b roc=%0d",
               name, out_valid, out_data, out_kind, busy, roc_count, ev, ed, ek, eb, er);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Full frame with aligned words
    vecs.push_back(mk(1, 4'h1, 1, 0, 0, 1, 0, 16'h0000, 2'd0, 1, 5'd0));
    vecs.push_back(mk(1, 4'h2, 0, 0, 0, 1, 0, 16'h0000, 2'd0, 1, 5'd0));
    vecs.push_back(mk(1, 4'h3, 0, 0, 0, 1, 0, 16'h0000, 2'd0, 1, 5'd0));
    vecs.push_back(mk(1, 4'h4, 0, 0, 0, 1, 1, 16'h1234, 2'd0, 1, 5'd0));
    vecs.push_back(mk(1, 4'h5, 0, 0, 1, 1, 0, 16'h0000, 2'd0, 1, 5'd1));
    vecs.push_back(mk(1, 4'h6, 0, 0, 0, 1, 0, 16'h0000, 2'd0, 1, 5'd1));
    vecs.push_back(mk(1, 4'h7, 0, 0, 0, 1, 0, 16'h0000, 2'd0, 1, 5'd1));
    vecs.push_back(mk(1, 4'h8, 0, 0, 0, 1, 1, 16'h5678, 2'd1, 1, 5'd1));
    vecs.push_back(mk(1, 4'h9, 0, 1, 0, 1, 0, 16'h0000, 2'd0, 1, 5'd1));
    vecs.push_back(mk(1, 4'hA, 0, 0, 0, 1, 0, 16'h0000, 2'd0, 1, 5'd1));
    vecs.push_back(mk(1, 4'hB, 0, 0, 0, 1, 0, 16'h0000, 2'd0, 1, 5'd1));
    vecs.push_back(mk(1, 4'hC, 0, 0, 0, 1, 1, 16'h9ABC, 2'd2, 1, 5'd1));
    vecs.push_back(mk(0, 4'h0, 0, 0, 0, 1, 1, 16'h0001, 2'd3, 0, 5'd1));
    vecs.push_back(mk(0, 4'h0, 0, 0, 0, 1, 0, 16'h0000, 2'd0, 0, 5'd1));
    // Short header flushed zero-padded by roc_hdr
    vecs.push_back(mk(1, 4'h1, 1, 0, 0, 1, 0, 16'h0000, 2'd0, 1, 5'd0));
    vecs.push_back(mk(1, 4'h2, 0, 0, 0, 1, 0, 16'h0000, 2'd0, 1, 5'd0));
    vecs.push_back(mk(1, 4'h3, 0, 0, 1, 1, 1, 16'h1200, 2'd0, 1, 5'd1));
    vecs.push_back(mk(1, 4'h4, 0, 0, 0, 1, 0, 16'h0000, 2'd0, 1, 5'd1));
    vecs.push_back(mk(1, 4'h5, 0, 0, 0, 1, 0, 16'h0000, 2'd0, 1, 5'd1));
    vecs.push_back(mk(1, 4'h6, 0, 0, 0, 1, 1, 16'h3456, 2'd1, 1, 5'd1));
    vecs.push_back(mk(1, 4'h7, 0, 1, 0, 1, 0, 16'h0000, 2'd0, 1, 5'd1));
    vecs.push_back(mk(1, 4'h8, 0, 0, 0, 1, 0, 16'h0000, 2'd0, 1, 5'd1));
    vecs.push_back(mk(1, 4'h9, 0, 0, 0, 1, 0, 16'h0000, 2'd0, 1, 5'd1));
    vecs.push_back(mk(1, 4'hA, 0, 0, 0, 1, 1, 16'h789A, 2'd2, 1, 5'd1));
    vecs.push_back(mk(0, 4'h0, 0, 0, 0, 1, 1, 16'h0001, 2'd3, 0, 5'd1));
    vecs.push_back(mk(0, 4'h0, 0, 0, 0, 1, 0, 16'h0000, 2'd0, 0, 5'd1));
    // tbm_hdr inside a ROC segment: partial, status with err_hdr, new frame
    vecs.push_back(mk(1, 4'h1, 1, 0, 0, 1, 0, 16'h0000, 2'd0, 1, 5'd0));
    vecs.push_back(mk(1, 4'h2, 0, 0, 0, 1, 0, 16'h0000, 2'd0, 1, 5'd0));
    vecs.push_back(mk(1, 4'h3, 0, 0, 0, 1, 0, 16'h0000, 2'd0, 1, 5'd0));
    vecs.push_back(mk(1, 4'h4, 0, 0, 0, 1, 1, 16'h1234, 2'd0, 1, 5'd0));
    vecs.push_back(mk(1, 4'h5, 0, 0, 1, 1, 0, 16'h0000, 2'd0, 1, 5'd1));
    vecs.push_back(mk(1, 4'h6, 0, 0, 0, 1, 0, 16'h0000, 2'd0, 1, 5'd1));
    vecs.push_back(mk(1, 4'h7, 1, 0, 0, 1, 1, 16'h5600, 2'd1, 1, 5'd1));
    vecs.push_back(mk(0, 4'h0, 0, 0, 0, 1, 1, 16'h2001, 2'd3, 1, 5'd0));
    vecs.push_back(mk(1, 4'h8, 0, 0, 0, 1, 0, 16'h0000, 2'd0, 1, 5'd0));
    vecs.push_back(mk(1, 4'h9, 0, 0, 0, 1, 0, 16'h0000, 2'd0, 1, 5'd0));
    vecs.push_back(mk(1, 4'hA, 0, 0, 0, 1, 1, 16'h789A, 2'd0, 1, 5'd0));
    vecs.push_back(mk(1, 4'hB, 0, 1, 0, 1, 0, 16'h0000, 2'd0, 1, 5'd0));
    vecs.push_back(mk(1, 4'hC, 0, 0, 0, 1, 0, 16'h0000, 2'd0, 1, 5'd0));
    vecs.push_back(mk(1, 4'hD, 0, 0, 0, 1, 0, 16'h0000, 2'd0, 1, 5'd0));
    vecs.push_back(mk(1, 4'hE, 0, 0, 0, 1, 1, 16'hBCDE, 2'd2, 1, 5'd0));
    vecs.push_back(mk(0, 4'h0, 0, 0, 0, 1, 1, 16'h0000, 2'd3, 0, 5'd0));
    vecs.push_back(mk(0, 4'h0, 0, 0, 0, 1, 0, 16'h0000, 2'd0, 0, 5'd0));
    // enable low: whole frame ignored
    vecs.push_back(mk(1, 4'h1, 1, 0, 0, 0, 0, 16'h0000, 2'd0, 0, 5'd0));
    vecs.push_back(mk(1, 4'h2, 0, 0, 0, 0, 0, 16'h0000, 2'd0, 0, 5'd0));
    vecs.push_back(mk(1, 4'h3, 0, 0, 0, 0, 0, 16'h0000, 2'd0, 0, 5'd0));
    vecs.push_back(mk(1, 4'h4, 0, 0, 0, 0, 0, 16'h0000, 2'd0, 0, 5'd0));
    vecs.push_back(mk(1, 4'h5, 0, 0, 1, 0, 0, 16'h0000, 2'd0, 0, 5'd0));
    vecs.push_back(mk(1, 4'h6, 0, 1, 0, 0, 0, 16'h0000, 2'd0, 0, 5'd0));

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 1'b0, 16'h0000, 2'd0, 1'b0, 5'd0);
    n_vec++;
    if (out_data !== 16'h0000 || out_kind !== 2'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got data=%h kind=%0d, want data=0000 kind=0", out_data, out_kind);
    end
    reset = 1'b0;

    // Table-driven frames
    foreach (vecs[i]) begin
      step(vecs[i].dav, vecs[i].din, vecs[i].th, vecs[i].tt, vecs[i].rh, vecs[i].en, 1'b1);
      check($sformatf("tbl[%0d]", i), vecs[i].ev, vecs[i].ed, vecs[i].ek, vecs[i].eb, vecs[i].er);
    end

    // Timeout inside a ROC segment with three nibbles pending
    step(1, 4'h1, 1, 0, 0, 1, 1);
    step(1, 4'h2, 0, 0, 0, 1, 1);
    step(1, 4'h3, 0, 0, 0, 1, 1);
    step(1, 4'h4, 0, 0, 0, 1, 1);
    check("tmo_hdr_word", 1'b1, 16'h1234, 2'd0, 1'b1, 5'd0);
    step(1, 4'h5, 0, 0, 1, 1, 1);
    step(1, 4'h6, 0, 0, 0, 1, 1);
    step(1, 4'h7, 0, 0, 0, 1, 1);
    for (int k = 1; k <= 7; k++) begin
      step(0, 4'h0, 0, 0, 0, 1, 1);
      check($sformatf("tmo_idle[%0d]", k), 1'b0, 16'h0000, 2'd0, 1'b1, 5'd1);
    end
    step(0, 4'h0, 0, 0, 0, 1, 1);
    check("tmo_partial", 1'b1, 16'h5670, 2'd1, 1'b1, 5'd1);
    step(0, 4'h0, 0, 0, 0, 1, 1);
    check("tmo_status", 1'b1, 16'h4001, 2'd3, 1'b0, 5'd1);
    step(0, 4'h0, 0, 0, 0, 1, 1);
    check("tmo_drained", 1'b0, 16'h0000, 2'd0, 1'b0, 5'd1);

    // Overflow: consumer stalled through a frame of five data words
    step(1, 4'h1, 1, 0, 0, 1, 0);
    step(1, 4'h2, 0, 0, 0, 1, 0);
    step(1, 4'h3, 0, 0, 0, 1, 0);
    step(1, 4'h4, 0, 0, 0, 1, 0);
    step(1, 4'h5, 0, 0, 1, 1, 0);
    step(1, 4'h6, 0, 0, 0, 1, 0);
    step(1, 4'h7, 0, 0, 0, 1, 0);
    step(1, 4'h8, 0, 0, 0, 1, 0);
    step(1, 4'h9, 0, 0, 1, 1, 0);
    step(1, 4'hA, 0, 0, 0, 1, 0);
    step(1, 4'hB, 0, 0, 0, 1, 0);
    step(1, 4'hC, 0, 0, 0, 1, 0);
    step(1, 4'hD, 0, 0, 1, 1, 0);
    step(1, 4'hE, 0, 0, 0, 1, 0);
    step(1, 4'hF, 0, 0, 0, 1, 0);
    step(1, 4'h0, 0, 0, 0, 1, 0);
    step(1, 4'h1, 0, 1, 0, 1, 0);
    step(1, 4'h2, 0, 0, 0, 1, 0);
    step(1, 4'h3, 0, 0, 0, 1, 0);
    step(1, 4'h4, 0, 0, 0, 1, 0);
    check("ovf_trl_end", 1'b1, 16'h1234, 2'd0, 1'b1, 5'd3);
    step(0, 4'h0, 0, 0, 0, 1, 0);
    check("ovf_stat_pushed", 1'b1, 16'h1234, 2'd0, 1'b0, 5'd3);
    step(0, 4'h0, 0, 0, 0, 1, 0);
    check("ovf_hold", 1'b1, 16'h1234, 2'd0, 1'b0, 5'd3);
    step(0, 4'h0, 0, 0, 0, 1, 1);
    check("ovf_word2", 1'b1, 16'h5678, 2'd1, 1'b0, 5'd3);
    step(0, 4'h0, 0, 0, 0, 1, 1);
    check("ovf_word3", 1'b1, 16'h9ABC, 2'd1, 1'b0, 5'd3);
    step(0, 4'h0, 0, 0, 0, 1, 1);
    check("ovf_status", 1'b1, 16'h8003, 2'd3, 1'b0, 5'd3);
    step(0, 4'h0, 0, 0, 0, 1, 1);
    check("ovf_empty", 1'b0, 16'h0000, 2'd0, 1'b0, 5'd3);

    // Reset mid-frame with a word buffered
    step(1, 4'h1, 1, 0, 0, 1, 0);
    step(1, 4'h2, 0, 0, 0, 1, 0);
    step(1, 4'h3, 0, 0, 0, 1, 0);
    step(1, 4'h4, 0, 0, 0, 1, 0);
    step(1, 4'h5, 0, 0, 1, 1, 0);
    check("rst_pre", 1'b1, 16'h1234, 2'd0, 1'b1, 5'd1);
    davail = 1'b0; tbm_hdr = 1'b0; tbm_trl = 1'b0; roc_hdr = 1'b0;
    reset = 1'b1;
    #1;
    check("rst_async", 1'b0, 16'h0000, 2'd0, 1'b0, 5'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(0, 4'h0, 0, 0, 0, 1, 1);
    check("rst_no_status", 1'b0, 16'h0000, 2'd0, 1'b0, 5'd0);
    step(0, 4'h0, 0, 0, 0, 1, 1);
    check("rst_quiet", 1'b0, 16'h0000, 2'd0, 1'b0, 5'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
